// File: rtl/thread_fetch_scheduler.sv
// Fetch-side thread scheduler: holds one PC per hardware thread, picks the next eligible thread
// round-robin and issues (tid, pc, pc+4) to instruction memory over a registered valid/ready request.
module thread_fetch_scheduler #(
  parameter int unsigned NUM_THREADS   = 8,
  parameter int unsigned TID_W         = 3,
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter logic [31:0] THREAD_STRIDE = 32'h0000_0400
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_THREADS-1:0] thread_en,
  input  logic                   redirect_valid,
  input  logic [TID_W-1:0]       redirect_tid,
  input  logic [31:0]            redirect_pc,
  output logic                   req_valid,
  input  logic                   req_ready,
  output logic [TID_W-1:0]       req_tid,
  output logic [31:0]            req_pc,
  output logic [31:0]            req_pcplus4,
  output logic [NUM_THREADS-1:0] inflight,
  output logic                   redirect_err
);

  localparam int unsigned PcW = 32;

  logic [PcW-1:0]         pcQ [NUM_THREADS];
  logic [PcW-1:0]         pcD [NUM_THREADS];
  logic [TID_W-1:0]       rrPtrQ;
  logic [TID_W-1:0]       rrPtrD;
  logic [NUM_THREADS-1:0] inflightD;
  logic                   redirectErrD;
  logic                   reqValidD;
  logic [TID_W-1:0]       reqTidD;
  logic [PcW-1:0]         reqPcD;
  logic [PcW-1:0]         reqPcPlus4D;

  logic [NUM_THREADS-1:0] eligible;
  logic                   anyEligible;
  logic [TID_W-1:0]       grantTid;
  logic [TID_W-1:0]       candTid;
  logic                   loadReq;

  // Round-robin arbiter: first eligible thread after rrPtrQ, wrapping; rrPtrQ itself is checked last.
  always_comb begin
    eligible    = thread_en & ~inflight;
    anyEligible = 1'b0;
    grantTid    = '0;
    candTid     = '0;
    for (int unsigned i = 1; i <= NUM_THREADS; i++) begin
      candTid = rrPtrQ + TID_W'(i);
      if (!anyEligible && eligible[candTid]) begin
        anyEligible = 1'b1;
        grantTid    = candTid;
      end
    end
  end

  assign loadReq = !req_valid || req_ready;

  // Next-state: redirect re-arms a thread; a grant (applied last) marks the granted thread in flight.
  always_comb begin
    pcD          = pcQ;
    rrPtrD       = rrPtrQ;
    inflightD    = inflight;
    redirectErrD = redirect_err;
    reqValidD    = req_valid;
    reqTidD      = req_tid;
    reqPcD       = req_pc;
    reqPcPlus4D  = req_pcplus4;

    if (redirect_valid) begin
      if (!inflight[redirect_tid]) begin
        redirectErrD = 1'b1;
      end
      inflightD[redirect_tid] = 1'b0;
      pcD[redirect_tid]       = redirect_pc;
    end

    if (loadReq) begin
      if (anyEligible) begin
        reqValidD           = 1'b1;
        reqTidD             = grantTid;
        reqPcD              = pcQ[grantTid];
        reqPcPlus4D         = pcQ[grantTid] + PcW'(4);
        inflightD[grantTid] = 1'b1;
        rrPtrD              = grantTid;
      end else begin
        reqValidD = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_THREADS; i++) begin
        pcQ[i] <= RESET_PC + (PcW'(i) * THREAD_STRIDE);
      end
      rrPtrQ       <= TID_W'(NUM_THREADS - 1);
      inflight     <= '0;
      redirect_err <= 1'b0;
      req_valid    <= 1'b0;
      req_tid      <= '0;
      req_pc       <= '0;
      req_pcplus4  <= '0;
    end else begin
      pcQ          <= pcD;
      rrPtrQ       <= rrPtrD;
      inflight     <= inflightD;
      redirect_err <= redirectErrD;
      req_valid    <= reqValidD;
      req_tid      <= reqTidD;
      req_pc       <= reqPcD;
      req_pcplus4  <= reqPcPlus4D;
    end
  end

endmodule

// File: tb/tb_thread_fetch_scheduler.sv
// Directed bench for thread_fetch_scheduler: hand-computed fetch sequences, stalls, redirects and reset.
module tb_thread_fetch_scheduler;

  logic        clk;
  logic        reset;
  logic [7:0]  thread_en;
  logic        redirect_valid;
  logic [2:0]  redirect_tid;
  logic [31:0] redirect_pc;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_tid;
  logic [31:0] req_pc;
  logic [31:0] req_pcplus4;
  logic [7:0]  inflight;
  logic        redirect_err;

  int checks   = 0;
  int failures = 0;

  thread_fetch_scheduler #(
    .NUM_THREADS(8), .TID_W(3), .RESET_PC(32'h0), .THREAD_STRIDE(32'h400)
  ) dut (
    .clk(clk), .reset(reset), .thread_en(thread_en),
    .redirect_valid(redirect_valid), .redirect_tid(redirect_tid), .redirect_pc(redirect_pc),
    .req_valid(req_valid), .req_ready(req_ready), .req_tid(req_tid), .req_pc(req_pc),
    .req_pcplus4(req_pcplus4), .inflight(inflight), .redirect_err(redirect_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge, then settle so outputs are sampled and inputs driven away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; thread_en = 8'hFF; req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_tid = '0; redirect_pc = '0;
    step(); step();
    checks++;
    if ({req_valid, req_tid, req_pc, req_pcplus4} !== 68'h0) begin
      failures++;
      $display("FAIL reset_req got v=%0b tid=%0d pc=%h p4=%h want all zero", req_valid, req_tid, req_pc, req_pcplus4);
    end
    checks++;
    if ({inflight, redirect_err} !== 9'h0) begin
      failures++;
      $display("FAIL reset_state got inflight=%h err=%0b want 00/0", inflight, redirect_err);
    end
    reset = 1'b0;
  endtask

  // Back-to-back grants: tids 0..7 on consecutive edges at their reset PCs.
  task automatic test_round_robin();
    logic [67:0] exp;
    for (int k = 0; k < 8; k++) begin
      step();
      exp = {1'b1, 3'(k), 32'(k) * 32'h400, 32'(k) * 32'h400 + 32'd4};
      checks++;
      if ({req_valid, req_tid, req_pc, req_pcplus4} !== exp) begin
        failures++;
        $display("FAIL rr_grant%0d got v=%0b tid=%0d pc=%h p4=%h want tid=%0d pc=%h",
                 k, req_valid, req_tid, req_pc, req_pcplus4, k, exp[63:32]);
      end
    end
    step();
    checks++;
    if ({req_valid, inflight} !== {1'b0, 8'hFF}) begin
      failures++;
      $display("FAIL rr_drain got v=%0b inflight=%h want 0/ff", req_valid, inflight);
    end
  endtask

  task automatic test_redirect();
    redirect_valid = 1'b1; redirect_tid = 3'd3; redirect_pc = 32'h0C04;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (req_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_no_bypass got v=%0b want 0", req_valid);
    end
    step();
    checks++;
    if ({req_valid, req_tid, req_pc, req_pcplus4} !== {1'b1, 3'd3, 32'h0C04, 32'h0C08}) begin
      failures++;
      $display("FAIL redir_grant got v=%0b tid=%0d pc=%h p4=%h want 1/3/00000c04/00000c08",
               req_valid, req_tid, req_pc, req_pcplus4);
    end
  endtask

  task automatic test_stall();
    redirect_valid = 1'b1; redirect_tid = 3'd2; redirect_pc = 32'h0808;
    step();
    redirect_tid = 3'd3; redirect_pc = 32'h0C08;
    step();
    redirect_valid = 1'b0; req_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if ({req_valid, req_tid, req_pc, req_pcplus4, inflight} !== {1'b1, 3'd2, 32'h0808, 32'h080C, 8'hF7}) begin
        failures++;
        $display("FAIL stall_hold%0d got v=%0b tid=%0d pc=%h p4=%h inflight=%h want 1/2/808/80c/f7",
                 c, req_valid, req_tid, req_pc, req_pcplus4, inflight);
      end
      step();
    end
    req_ready = 1'b1;
    step();
    checks++;
    if ({req_valid, req_tid, req_pc, inflight} !== {1'b1, 3'd3, 32'h0C08, 8'hFF}) begin
      failures++;
      $display("FAIL stall_release got v=%0b tid=%0d pc=%h inflight=%h want 1/3/c08/ff",
               req_valid, req_tid, req_pc, inflight);
    end
  endtask

  // Only threads 0 and 2 enabled; they alternate as their redirects come back.
  task automatic test_thread_enable();
    logic [7:0] seen;
    seen = '0;
    reset = 1'b1; thread_en = 8'b0000_0101;
    step();
    reset = 1'b0;
    step();
    if (req_valid) seen[req_tid] = 1'b1;
    checks++;
    if ({req_valid, req_tid, req_pc} !== {1'b1, 3'd0, 32'h0}) begin
      failures++;
      $display("FAIL en_first got v=%0b tid=%0d pc=%h want 1/0/0", req_valid, req_tid, req_pc);
    end
    step();
    if (req_valid) seen[req_tid] = 1'b1;
    checks++;
    if ({req_valid, req_tid, req_pc} !== {1'b1, 3'd2, 32'h0800}) begin
      failures++;
      $display("FAIL en_second got v=%0b tid=%0d pc=%h want 1/2/800", req_valid, req_tid, req_pc);
    end
    step();
    for (int k = 1; k <= 3; k++) begin
      redirect_valid = 1'b1; redirect_tid = 3'd0; redirect_pc = 32'(4 * k);
      step();
      if (req_valid) seen[req_tid] = 1'b1;
      redirect_tid = 3'd2; redirect_pc = 32'h0800 + 32'(4 * k);
      step();
      if (req_valid) seen[req_tid] = 1'b1;
      checks++;
      if ({req_valid, req_tid, req_pc} !== {1'b1, 3'd0, 32'(4 * k)}) begin
        failures++;
        $display("FAIL en_alt0_%0d got v=%0b tid=%0d pc=%h want tid 0 pc %h", k, req_valid, req_tid, req_pc, 4 * k);
      end
      redirect_valid = 1'b0;
      step();
      if (req_valid) seen[req_tid] = 1'b1;
      checks++;
      if ({req_valid, req_tid, req_pc} !== {1'b1, 3'd2, 32'h0800 + 32'(4 * k)}) begin
        failures++;
        $display("FAIL en_alt2_%0d got v=%0b tid=%0d pc=%h want tid 2", k, req_valid, req_tid, req_pc);
      end
    end
    checks++;
    if ({seen, inflight} !== {8'h05, 8'h05}) begin
      failures++;
      $display("FAIL en_only02 got seen=%h inflight=%h want 05/05", seen, inflight);
    end
  endtask

  task automatic test_redirect_err();
    logic [2:0]  expTid [5] = '{3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    logic [31:0] expPc  [5] = '{32'h2000, 32'h1800, 32'h1C00, 32'h0100, 32'h0400};
    checks++;
    if (redirect_err !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got %0b want 0", redirect_err);
    end
    thread_en = 8'hFF;
    redirect_valid = 1'b1; redirect_tid = 3'd5; redirect_pc = 32'h2000;
    step();
    checks++;
    if ({redirect_err, req_valid, req_tid, req_pc, req_pcplus4} !== {1'b1, 1'b1, 3'd3, 32'h0C00, 32'h0C04}) begin
      failures++;
      $display("FAIL err_set got err=%0b v=%0b tid=%0d pc=%h p4=%h want 1/1/3/c00/c04",
               redirect_err, req_valid, req_tid, req_pc, req_pcplus4);
    end
    redirect_tid = 3'd0; redirect_pc = 32'h0100;
    step();
    redirect_valid = 1'b0;
    checks++;
    if ({req_valid, req_tid, req_pc, inflight[0]} !== {1'b1, 3'd4, 32'h1000, 1'b0}) begin
      failures++;
      $display("FAIL err_same_edge got v=%0b tid=%0d pc=%h if0=%0b want 1/4/1000/0",
               req_valid, req_tid, req_pc, inflight[0]);
    end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if ({req_valid, req_tid, req_pc, req_pcplus4} !== {1'b1, expTid[k], expPc[k], expPc[k] + 32'd4}) begin
        failures++;
        $display("FAIL err_seq%0d got v=%0b tid=%0d pc=%h p4=%h want tid=%0d pc=%h",
                 k, req_valid, req_tid, req_pc, req_pcplus4, expTid[k], expPc[k]);
      end
    end
    step();
    checks++;
    if ({req_valid, inflight, redirect_err} !== {1'b0, 8'hFF, 1'b1}) begin
      failures++;
      $display("FAIL err_sticky got v=%0b inflight=%h err=%0b want 0/ff/1", req_valid, inflight, redirect_err);
    end
  endtask

  task automatic test_reset_midstream();
    req_ready = 1'b0;
    redirect_valid = 1'b1; redirect_tid = 3'd6; redirect_pc = 32'h1804;
    step();
    redirect_valid = 1'b0;
    step();
    step();
    checks++;
    if ({req_valid, req_tid, req_pc} !== {1'b1, 3'd6, 32'h1804}) begin
      failures++;
      $display("FAIL mid_stalled got v=%0b tid=%0d pc=%h want 1/6/1804", req_valid, req_tid, req_pc);
    end
    reset = 1'b1;
    step();
    checks++;
    if ({req_valid, inflight, redirect_err, req_tid, req_pc} !== {1'b0, 8'h00, 1'b0, 3'd0, 32'h0}) begin
      failures++;
      $display("FAIL mid_reset got v=%0b inflight=%h err=%0b tid=%0d pc=%h want all zero",
               req_valid, inflight, redirect_err, req_tid, req_pc);
    end
    reset = 1'b0; req_ready = 1'b1; thread_en = 8'h01;
    step();
    checks++;
    if ({req_valid, req_tid, req_pc, req_pcplus4} !== {1'b1, 3'd0, 32'h0, 32'h4}) begin
      failures++;
      $display("FAIL mid_restart got v=%0b tid=%0d pc=%h p4=%h want 1/0/0/4", req_valid, req_tid, req_pc, req_pcplus4);
    end
    redirect_valid = 1'b1; redirect_tid = 3'd0; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    checks++;
    if ({req_valid, req_tid, req_pc, req_pcplus4} !== {1'b1, 3'd0, 32'hFFFF_FFFC, 32'h0}) begin
      failures++;
      $display("FAIL pc_wrap got v=%0b tid=%0d pc=%h p4=%h want 1/0/fffffffc/0", req_valid, req_tid, req_pc, req_pcplus4);
    end
  endtask

  initial begin
    reset = 1'b1; thread_en = 8'hFF; req_ready = 1'b1;
    redirect_valid = 1'b0; redirect_tid = '0; redirect_pc = '0;
    test_reset();
    test_round_robin();
    test_redirect();
    test_stall();
    test_thread_enable();
    test_redirect_err();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
